// File: rtl/mton_rd_dispatch_pkg.sv
// Shared constants for the M:N FIFO read-side dispatcher.
// Lane index width is derived from the lane count at elaboration.
package mtoN_pkg;

  localparam int CNT_W_DEF = 16;

  function automatic int lane_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mton_rd_dispatch_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr.
// Produces a one-hot grant and its binary index.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] k;

  // Scan from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    k     = '0;
    for (int off = N - 1; off >= 0; off--) begin
      k = IW'((int'(ptr_i) + off) % N);
      if (req_i[k]) begin
        gnt_o    = '0;
        gnt_o[k] = 1'b1;
        idx_o    = k;
      end
    end
  end

endmodule

// File: rtl/mton_rd_dispatch.sv
// Pops FWFT FIFO words into a hold register and hands them to N lanes,
// round-robin or broadcast, with per-lane saturating transfer counters.
module mton_rd_dispatch
  import mtoN_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int N_READERS = 2,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_fifo_empty,
  input  logic [WIDTH-1:0]           i_fifo_data,
  output logic                       o_fifo_rd,
  input  logic [N_READERS-1:0]       i_lane_en,
  input  logic                       i_bcast,
  output logic [N_READERS-1:0]       o_rd_valid,
  output logic [N_READERS*WIDTH-1:0] o_rd_data,
  input  logic [N_READERS-1:0]       i_rd_ready,
  output logic [N_READERS*CNT_W-1:0] o_lane_cnt,
  output logic                       o_busy
);

  localparam int IW = lane_idx_w(N_READERS);

  logic                 hold_v_q, hold_v_d;
  logic [WIDTH-1:0]     hold_data_q;
  logic [N_READERS-1:0] lane_v_q, lane_v_d;
  logic [WIDTH-1:0]     lane_d_q [N_READERS];
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     cnt_q [N_READERS];

  logic [N_READERS-1:0] free, xfer, rr_gnt, load;
  logic [IW-1:0]        rr_idx;
  logic                 bcast_ok, grant, pop;

  assign free = i_lane_en & (~lane_v_q | i_rd_ready);
  assign xfer = lane_v_q & i_rd_ready;

  rr_arbiter #(
    .N  (N_READERS),
    .IW (IW)
  ) u_arb (
    .req_i (free),
    .ptr_i (rr_ptr_q),
    .gnt_o (rr_gnt),
    .idx_o (rr_idx)
  );

  // Broadcast waits until every enabled lane can accept at once.
  assign bcast_ok = (|i_lane_en) & (&(free | ~i_lane_en));

  always_comb begin
    load = '0;
    if (hold_v_q) begin
      if (i_bcast) begin
        if (bcast_ok) load = i_lane_en;
      end else begin
        load = rr_gnt;
      end
    end
  end

  assign grant = |load;
  assign pop   = ~i_rst & ~i_fifo_empty & (~hold_v_q | grant);

  always_comb begin
    hold_v_d = hold_v_q;
    if (pop)        hold_v_d = 1'b1;
    else if (grant) hold_v_d = 1'b0;
    lane_v_d = load | (lane_v_q & ~xfer);
    rr_ptr_d = rr_ptr_q;
    if (!i_bcast && grant) begin
      if (rr_idx == IW'(N_READERS - 1)) rr_ptr_d = '0;
      else                              rr_ptr_d = rr_idx + IW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hold_v_q <= 1'b0;
      lane_v_q <= '0;
      rr_ptr_q <= '0;
      for (int k = 0; k < N_READERS; k++) cnt_q[k] <= '0;
    end else begin
      hold_v_q <= hold_v_d;
      lane_v_q <= lane_v_d;
      rr_ptr_q <= rr_ptr_d;
      for (int k = 0; k < N_READERS; k++) begin
        if (xfer[k] && !(&cnt_q[k])) cnt_q[k] <= cnt_q[k] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (pop) hold_data_q <= i_fifo_data;
    for (int k = 0; k < N_READERS; k++) begin
      if (load[k]) lane_d_q[k] <= hold_data_q;
    end
  end

  for (genvar g = 0; g < N_READERS; g++) begin : g_out
    assign o_rd_data[g*WIDTH +: WIDTH]  = lane_d_q[g];
    assign o_lane_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end

  assign o_fifo_rd  = pop;
  assign o_rd_valid = lane_v_q;
  assign o_busy     = hold_v_q | (|lane_v_q);

endmodule

// File: tb/tb_mton_rd_dispatch.sv
// Directed bench: a 2-lane dispatcher for ordering, backpressure and reset,
// and a 3-lane one with 4-bit counters for broadcast and saturation.
module tb_mton_rd_dispatch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int p;

  logic        a_empty = 1'b1;
  logic [7:0]  a_fdata = '0;
  logic        a_rd;
  logic [1:0]  a_en    = 2'b11;
  logic        a_bcast = 1'b0;
  logic [1:0]  a_valid;
  logic [15:0] a_data;
  logic [1:0]  a_ready = 2'b00;
  logic [31:0] a_cnt;
  logic        a_busy;

  logic        b_empty = 1'b1;
  logic [7:0]  b_fdata = '0;
  logic        b_rd;
  logic [2:0]  b_en    = 3'b111;
  logic        b_bcast = 1'b0;
  logic [2:0]  b_valid;
  logic [23:0] b_data;
  logic [2:0]  b_ready = 3'b000;
  logic [11:0] b_cnt;
  logic        b_busy;

  logic [7:0] qa[$], qb[$];
  logic [7:0] ga0[$], ga1[$], gb0[$];
  int a_pops = 0;
  int b_pops = 0;

  mton_rd_dispatch #(.WIDTH(8), .N_READERS(2), .CNT_W(16)) u_a (
    .i_clk(clk), .i_rst(rst),
    .i_fifo_empty(a_empty), .i_fifo_data(a_fdata), .o_fifo_rd(a_rd),
    .i_lane_en(a_en), .i_bcast(a_bcast),
    .o_rd_valid(a_valid), .o_rd_data(a_data), .i_rd_ready(a_ready),
    .o_lane_cnt(a_cnt), .o_busy(a_busy)
  );

  mton_rd_dispatch #(.WIDTH(8), .N_READERS(3), .CNT_W(4)) u_b (
    .i_clk(clk), .i_rst(rst),
    .i_fifo_empty(b_empty), .i_fifo_data(b_fdata), .o_fifo_rd(b_rd),
    .i_lane_en(b_en), .i_bcast(b_bcast),
    .o_rd_valid(b_valid), .o_rd_data(b_data), .i_rd_ready(b_ready),
    .o_lane_cnt(b_cnt), .o_busy(b_busy)
  );

  // FWFT FIFO models and lane transfer monitors.
  always @(posedge clk) begin
    if (a_rd) begin void'(qa.pop_front()); a_pops++; end
    if (b_rd) begin void'(qb.pop_front()); b_pops++; end
    if (a_valid[0] && a_ready[0]) ga0.push_back(a_data[7:0]);
    if (a_valid[1] && a_ready[1]) ga1.push_back(a_data[15:8]);
    if (b_valid[0] && b_ready[0]) gb0.push_back(b_data[7:0]);
  end

  always @(negedge clk) begin
    a_empty = (qa.size() == 0);
    a_fdata = (qa.size() != 0) ? qa[0] : 8'h00;
    b_empty = (qb.size() == 0);
    b_fdata = (qb.size() != 0) ? qb[0] : 8'h00;
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_got();
    ga0.delete(); ga1.delete(); gb0.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(2);
    qa.push_back(8'h99);
    cyc(2);
    checks++;
    if (a_rd !== 1'b0) begin errors++;
      $display("FAIL reset_pop: got %b want 0", a_rd); end
    checks++;
    if (a_pops != 0) begin errors++;
      $display("FAIL reset_pops: got %0d want 0", a_pops); end
    qa.delete();
    cyc(1);
    rst = 1'b0;
    checks++;
    if (a_valid !== 2'b00 || a_busy !== 1'b0) begin errors++;
      $display("FAIL reset_a: valid %b busy %b want 00 0", a_valid, a_busy); end
    checks++;
    if (a_cnt !== 32'h0) begin errors++;
      $display("FAIL reset_a_cnt: got %h want 0", a_cnt); end
    checks++;
    if (b_valid !== 3'b000 || b_busy !== 1'b0 || b_cnt !== 12'h0) begin errors++;
      $display("FAIL reset_b: valid %b busy %b cnt %h", b_valid, b_busy, b_cnt); end
    cyc(2);
    checks++;
    if (a_pops != 0 || a_busy !== 1'b0) begin errors++;
      $display("FAIL idle_empty: pops %0d busy %b want 0 0", a_pops, a_busy); end
  endtask

  task automatic test_basic();
    clear_got();
    a_ready = 2'b11; a_en = 2'b11;
    p = a_pops;
    qa.push_back(8'h11); qa.push_back(8'h22);
    qa.push_back(8'h33); qa.push_back(8'h44);
    cyc(1);
    checks++;
    if (a_valid !== 2'b00 || a_busy !== 1'b1) begin errors++;
      $display("FAIL basic_hold: valid %b busy %b want 00 1", a_valid, a_busy); end
    cyc(1);
    checks++;
    if (a_valid !== 2'b01 || a_data[7:0] !== 8'h11) begin errors++;
      $display("FAIL basic_latency: valid %b d0 %h want 01 11", a_valid, a_data[7:0]); end
    cyc(6);
    checks++;
    if (ga0.size() != 2 || ga0[0] !== 8'h11 || ga0[1] !== 8'h33) begin errors++;
      $display("FAIL basic_lane0: n %0d %h %h want 2 11 33", ga0.size(), ga0[0], ga0[1]); end
    checks++;
    if (ga1.size() != 2 || ga1[0] !== 8'h22 || ga1[1] !== 8'h44) begin errors++;
      $display("FAIL basic_lane1: n %0d %h %h want 2 22 44", ga1.size(), ga1[0], ga1[1]); end
    checks++;
    if (a_cnt !== {16'd2, 16'd2} || a_pops - p != 4) begin errors++;
      $display("FAIL basic_cnt: cnt %h pops %0d want 00020002 4", a_cnt, a_pops - p); end
    checks++;
    if (a_busy !== 1'b0) begin errors++;
      $display("FAIL basic_idle: busy %b want 0", a_busy); end
  endtask

  task automatic test_backpressure();
    clear_got();
    a_ready = 2'b01;
    p = a_pops;
    for (int i = 1; i <= 5; i++) qa.push_back(8'(8'h11 * i));
    cyc(3);
    checks++;
    if (a_valid !== 2'b10 || a_data[15:8] !== 8'h22) begin errors++;
      $display("FAIL bp_lane1: valid %b d1 %h want 10 22", a_valid, a_data[15:8]); end
    a_ready = 2'b00;
    cyc(4);
    checks++;
    if (a_pops - p != 4) begin errors++;
      $display("FAIL bp_stall: pops %0d want 4", a_pops - p); end
    checks++;
    if (a_valid !== 2'b11 || a_data !== 16'h2233) begin errors++;
      $display("FAIL bp_stable: valid %b data %h want 11 2233", a_valid, a_data); end
    a_ready = 2'b11;
    cyc(5);
    checks++;
    if (ga0.size() != 3 || ga0[0] !== 8'h11 || ga0[1] !== 8'h33 || ga0[2] !== 8'h55) begin
      errors++;
      $display("FAIL bp_lane0: n %0d %h %h %h want 3 11 33 55",
               ga0.size(), ga0[0], ga0[1], ga0[2]); end
    checks++;
    if (ga1.size() != 2 || ga1[0] !== 8'h22 || ga1[1] !== 8'h44) begin errors++;
      $display("FAIL bp_lane1_order: n %0d %h %h want 2 22 44", ga1.size(), ga1[0], ga1[1]); end
  endtask

  task automatic test_disabled();
    clear_got();
    a_en = 2'b00; a_ready = 2'b11;
    p = a_pops;
    qa.push_back(8'hAA); qa.push_back(8'hBB); qa.push_back(8'hCC);
    cyc(4);
    checks++;
    if (a_pops - p != 1 || a_valid !== 2'b00 || a_busy !== 1'b1) begin errors++;
      $display("FAIL dis_stall: pops %0d valid %b busy %b want 1 00 1",
               a_pops - p, a_valid, a_busy); end
    a_en = 2'b10;
    cyc(6);
    checks++;
    if (ga1.size() != 3 || ga1[0] !== 8'hAA || ga1[1] !== 8'hBB || ga1[2] !== 8'hCC) begin
      errors++;
      $display("FAIL dis_order: n %0d %h %h %h want 3 aa bb cc",
               ga1.size(), ga1[0], ga1[1], ga1[2]); end
    checks++;
    if (ga0.size() != 0 || a_pops - p != 3) begin errors++;
      $display("FAIL dis_lane0: n %0d pops %0d want 0 3", ga0.size(), a_pops - p); end
  endtask

  task automatic test_reset_mid();
    clear_got();
    a_en = 2'b01; a_ready = 2'b00;
    for (int i = 1; i <= 4; i++) qa.push_back(8'(i));
    cyc(3);
    checks++;
    if (a_valid !== 2'b01 || a_busy !== 1'b1) begin errors++;
      $display("FAIL rm_pre: valid %b busy %b want 01 1", a_valid, a_busy); end
    rst = 1'b1;
    cyc(1);
    checks++;
    if (a_valid !== 2'b00 || a_busy !== 1'b0 || a_cnt !== 32'h0) begin errors++;
      $display("FAIL rm_clear: valid %b busy %b cnt %h", a_valid, a_busy, a_cnt); end
    rst = 1'b0; a_en = 2'b11; a_ready = 2'b11;
    cyc(1);
    checks++;
    if (a_valid !== 2'b00) begin errors++;
      $display("FAIL rm_hold: valid %b want 00", a_valid); end
    cyc(1);
    checks++;
    if (a_valid !== 2'b01 || a_data[7:0] !== 8'h03) begin errors++;
      $display("FAIL rm_lane0: valid %b d0 %h want 01 03", a_valid, a_data[7:0]); end
    cyc(4);
  endtask

  task automatic test_broadcast();
    b_bcast = 1'b1; b_en = 3'b101; b_ready = 3'b111;
    qb.push_back(8'hA5); qb.push_back(8'h5A);
    cyc(2);
    checks++;
    if (b_valid !== 3'b101 || b_data[7:0] !== 8'hA5 || b_data[23:16] !== 8'hA5) begin
      errors++;
      $display("FAIL bc_first: valid %b data %h want 101 a5xxa5", b_valid, b_data); end
    b_ready = 3'b110;
    cyc(2);
    checks++;
    if (b_valid !== 3'b001 || b_data[7:0] !== 8'hA5 || b_busy !== 1'b1) begin errors++;
      $display("FAIL bc_wait: valid %b d0 %h busy %b want 001 a5 1",
               b_valid, b_data[7:0], b_busy); end
    b_ready = 3'b111;
    cyc(1);
    checks++;
    if (b_valid !== 3'b101 || b_data[7:0] !== 8'h5A || b_data[23:16] !== 8'h5A) begin
      errors++;
      $display("FAIL bc_second: valid %b data %h want 101 5axx5a", b_valid, b_data); end
    cyc(3);
    checks++;
    if (b_cnt !== 12'h202) begin errors++;
      $display("FAIL bc_cnt: got %h want 202", b_cnt); end
  endtask

  task automatic test_saturate();
    b_bcast = 1'b0; b_en = 3'b111;
    qb.push_back(8'h77);
    cyc(2);
    checks++;
    if (b_valid !== 3'b001 || b_data[7:0] !== 8'h77) begin errors++;
      $display("FAIL rr_after_bc: valid %b d0 %h want 001 77", b_valid, b_data[7:0]); end
    cyc(2);
    checks++;
    if (b_cnt[3:0] !== 4'd3) begin errors++;
      $display("FAIL cnt_pre: got %0d want 3", b_cnt[3:0]); end
    clear_got();
    b_en = 3'b001;
    for (int i = 0; i < 20; i++) qb.push_back(8'(8'h30 + i));
    cyc(22);
    checks++;
    if (gb0.size() != 20 || gb0[19] !== 8'h43) begin errors++;
      $display("FAIL sat_thru: n %0d last %h want 20 43", gb0.size(), gb0[19]); end
    checks++;
    if (b_cnt !== 12'h20F) begin errors++;
      $display("FAIL sat_cnt: got %h want 20f", b_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_disabled();
    test_reset_mid();
    test_broadcast();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
